// File: rtl/ibex_vrf_wb_arbiter.sv
// ============================================================================
//  Module      : ibex_vrf_wb_arbiter
//  Description : Arbitrates ALU, vector-load and vtype-update requests onto a
//                single vector register-file write port. LSU has priority,
//                the ALU is promoted after STARVE_LIMIT lost cycles, and
//                config updates drain the write path before being applied.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ibex_vrf_wb_arbiter #(
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic         clk_i,
    input  logic         rst_i,

    input  logic         alu_valid_i,
    output logic         alu_ready_o,
    input  logic [4:0]   alu_waddr_i,
    input  logic [127:0] alu_wdata_i,
    input  logic [3:0]   alu_wnum_i,

    input  logic         lsu_valid_i,
    output logic         lsu_ready_o,
    input  logic [4:0]   lsu_waddr_i,
    input  logic [127:0] lsu_wdata_i,

    input  logic         cfg_valid_i,
    output logic         cfg_ready_o,
    input  logic [2:0]   cfg_vsew_i,
    input  logic [2:0]   cfg_vlmul_i,

    output logic [2:0]   vsew_o,
    output logic [2:0]   vlmul_o,

    output logic         v_we_o,
    output logic [4:0]   v_waddr_o,
    output logic [127:0] v_wdata_o,
    output logic [3:0]   v_wnum_o,
    output logic         v_load_en_o,

    output logic [31:0]  busy_o,
    output logic         err_o
);

    localparam logic [2:0] c_VSEW_RST  = 3'b010;
    localparam logic [2:0] c_VLMUL_RST = 3'b000;

    logic [1:0]   r_alu_wait;
    logic         r_we;
    logic [4:0]   r_waddr;
    logic [127:0] r_wdata;
    logic [3:0]   r_wnum;
    logic         r_load;
    logic         r_err;
    logic [2:0]   r_vsew;
    logic [2:0]   r_vlmul;

    logic         w_starved;
    logic         w_open;
    logic         w_alu_grant;
    logic         w_lsu_grant;
    logic         w_cfg_xfer;
    logic         w_wnum_ok;
    logic         w_cfg_ok;
    logic         w_wide;
    logic [4:0]   w_grp_addr;

    assign w_starved = ({30'd0, r_alu_wait} >= STARVE_LIMIT);
    // Write requesters are held off during reset and while a config update drains.
    assign w_open      = !rst_i && !cfg_valid_i;
    assign w_alu_grant = w_open && alu_valid_i && (!lsu_valid_i || w_starved);
    assign w_lsu_grant = w_open && lsu_valid_i && !(alu_valid_i && w_starved);

    assign alu_ready_o = w_alu_grant;
    assign lsu_ready_o = w_lsu_grant;
    assign cfg_ready_o = !rst_i && cfg_valid_i && !v_we_o;
    assign w_cfg_xfer  = cfg_ready_o;

    assign w_wnum_ok = (alu_wnum_i == 4'b0001) || (alu_wnum_i == 4'b0011) ||
                       (alu_wnum_i == 4'b0111) || (alu_wnum_i == 4'b1111);
    assign w_cfg_ok  = (cfg_vsew_i <= 3'd2) && (cfg_vlmul_i <= 3'd2);

    // Registered state is masked while reset is high so a write captured just
    // before reset never reaches the register file.
    assign v_we_o      = r_we && !rst_i;
    assign v_waddr_o   = rst_i ? 5'd0   : r_waddr;
    assign v_wdata_o   = rst_i ? 128'd0 : r_wdata;
    assign v_wnum_o    = rst_i ? 4'd0   : r_wnum;
    assign v_load_en_o = r_load && !rst_i;
    assign err_o       = r_err && !rst_i;
    assign vsew_o      = rst_i ? c_VSEW_RST  : r_vsew;
    assign vlmul_o     = rst_i ? c_VLMUL_RST : r_vlmul;

    // ALU starvation counter: saturates while losing, clears when served.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_alu_wait <= 2'd0;
        end else if (w_alu_grant) begin
            r_alu_wait <= 2'd0;
        end else if (alu_valid_i && (r_alu_wait != 2'd3)) begin
            r_alu_wait <= r_alu_wait + 2'd1;
        end
    end

    // Capture the granted write (or nothing) and raise error pulses.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_we    <= 1'b0;
            r_waddr <= 5'd0;
            r_wdata <= 128'd0;
            r_wnum  <= 4'd0;
            r_load  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_we    <= 1'b0;
            r_waddr <= 5'd0;
            r_wdata <= 128'd0;
            r_wnum  <= 4'd0;
            r_load  <= 1'b0;
            r_err   <= (w_alu_grant && !w_wnum_ok) || (w_cfg_xfer && !w_cfg_ok);
            if (w_lsu_grant) begin
                r_we    <= 1'b1;
                r_waddr <= lsu_waddr_i;
                r_wdata <= lsu_wdata_i;
                r_wnum  <= 4'b1111;
                r_load  <= 1'b1;
            end else if (w_alu_grant && w_wnum_ok) begin
                r_we    <= 1'b1;
                r_waddr <= alu_waddr_i;
                r_wdata <= alu_wdata_i;
                r_wnum  <= alu_wnum_i;
            end
        end
    end

    // vtype register; illegal encodings are rejected and leave it untouched.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_vsew  <= c_VSEW_RST;
            r_vlmul <= c_VLMUL_RST;
        end else if (w_cfg_xfer && w_cfg_ok) begin
            r_vsew  <= cfg_vsew_i;
            r_vlmul <= cfg_vlmul_i;
        end
    end

    // Wide-element ALU writes also reach the neighbouring registers waddr|1..3.
    assign w_wide = !r_load &&
                    (((r_vsew == 3'b001) && ((r_wnum == 4'b0111) || (r_wnum == 4'b1111))) ||
                     (r_vsew == 3'b010));

    // Busy mask: union of the LMUL-aligned groups touched by the current write.
    always_comb begin
        busy_o     = 32'd0;
        w_grp_addr = 5'd0;
        if (v_we_o) begin
            for (int k = 0; k < 4; k++) begin
                if ((k == 0) || w_wide) begin
                    w_grp_addr = r_waddr | 5'(k);
                    case (r_vlmul)
                        3'b001: begin
                            for (int j = 0; j < 2; j++) begin
                                busy_o[{w_grp_addr[4:1], 1'(j)}] = 1'b1;
                            end
                        end
                        3'b010: begin
                            for (int j = 0; j < 4; j++) begin
                                busy_o[{w_grp_addr[4:2], 2'(j)}] = 1'b1;
                            end
                        end
                        default: busy_o[w_grp_addr] = 1'b1;
                    endcase
                end
            end
        end
    end

endmodule

`default_nettype wire
